// File: rtl/btn_pkg.sv
// Shared types and width helpers for the multi-channel button conditioner.
package btn_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      HELD    = 2'd2
   } state_t;

   localparam int MIN_CNT_W = 1;

   // Bits needed for a counter spanning 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      if (n <= 2) return MIN_CNT_W;
      return $clog2(n);
   endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: synchroniser, tick-sampled debouncer, edge pulses and
// the IDLE/PRESSED/HELD long-press / auto-repeat state machine.
module btn_channel
   import btn_pkg::*;
#(
   parameter int SYNC_STAGES  = 2,
   parameter int DB_SAMPLES   = 3,
   parameter int HOLD_TICKS   = 200,
   parameter int REPEAT_TICKS = 50
) (
   input  logic   i_clk,
   input  logic   i_rst,
   input  logic   i_tick,
   input  logic   i_btn,
   input  logic   i_repeat_en,
   output logic   o_level,
   output logic   o_press,
   output logic   o_release,
   output logic   o_long_press,
   output logic   o_repeat_pulse,
   output state_t o_state
);

   localparam int DB_W  = cnt_w(DB_SAMPLES);
   localparam int HLD_W = cnt_w(HOLD_TICKS);
   localparam int REP_W = cnt_w(REPEAT_TICKS);

   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_SAMPLES - 1);
   localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'(HOLD_TICKS - 1);
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_TICKS - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [DB_W-1:0]        r_db_cnt;
   logic                   r_level;
   logic                   r_press;
   logic                   r_release;
   logic                   r_long;
   logic                   r_repeat;
   state_t                 r_state;
   logic [HLD_W-1:0]       r_hold_cnt;
   logic [REP_W-1:0]       r_rep_cnt;

   logic                   w_sync;
   logic                   w_differ;
   logic                   w_toggle;
   logic                   w_rise;
   logic                   w_fall;
   state_t                 w_state_nxt;
   logic [HLD_W-1:0]       w_hold_nxt;
   logic [REP_W-1:0]       w_rep_nxt;
   logic                   w_long_nxt;
   logic                   w_repeat_nxt;

   assign w_sync   = r_sync[SYNC_STAGES-1];
   assign w_differ = w_sync != r_level;
   assign w_toggle = i_tick && w_differ && (r_db_cnt == DB_LAST);
   assign w_rise   = w_toggle && !r_level;
   assign w_fall   = w_toggle && r_level;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync    <= '0;
         r_db_cnt  <= '0;
         r_level   <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
      end else begin
         r_sync    <= {r_sync[SYNC_STAGES-2:0], i_btn};
         r_press   <= w_rise;
         r_release <= w_fall;
         if (i_tick) begin
            if (!w_differ) begin
               r_db_cnt <= '0;
            end else if (w_toggle) begin
               r_level  <= ~r_level;
               r_db_cnt <= '0;
            end else if (r_db_cnt != DB_LAST) begin
               r_db_cnt <= r_db_cnt + DB_W'(1);
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= IDLE;
         r_hold_cnt <= '0;
         r_rep_cnt  <= '0;
         r_long     <= 1'b0;
         r_repeat   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_hold_cnt <= w_hold_nxt;
         r_rep_cnt  <= w_rep_nxt;
         r_long     <= w_long_nxt;
         r_repeat   <= w_repeat_nxt;
      end
   end

   // A debounced fall outranks any hold/repeat threshold landing on the same tick.
   always_comb begin
      w_state_nxt  = r_state;
      w_hold_nxt   = r_hold_cnt;
      w_rep_nxt    = r_rep_cnt;
      w_long_nxt   = 1'b0;
      w_repeat_nxt = 1'b0;
      if (w_fall) begin
         w_state_nxt = IDLE;
         w_hold_nxt  = '0;
         w_rep_nxt   = '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_rise) begin
                  w_state_nxt = PRESSED;
                  w_hold_nxt  = '0;
               end
            end
            PRESSED: begin
               if (i_tick) begin
                  if (r_hold_cnt == HLD_LAST) begin
                     w_long_nxt  = 1'b1;
                     w_state_nxt = HELD;
                     w_rep_nxt   = '0;
                  end else begin
                     w_hold_nxt = r_hold_cnt + HLD_W'(1);
                  end
               end
            end
            HELD: begin
               if (!i_repeat_en) begin
                  w_rep_nxt = '0;
               end else if (i_tick) begin
                  if (r_rep_cnt == REP_LAST) begin
                     w_repeat_nxt = 1'b1;
                     w_rep_nxt    = '0;
                  end else begin
                     w_rep_nxt = r_rep_cnt + REP_W'(1);
                  end
               end
            end
            default: begin
               w_state_nxt = IDLE;
               w_hold_nxt  = '0;
               w_rep_nxt   = '0;
            end
         endcase
      end
   end

   assign o_level        = r_level;
   assign o_press        = r_press;
   assign o_release      = r_release;
   assign o_long_press   = r_long;
   assign o_repeat_pulse = r_repeat;
   assign o_state        = r_state;

endmodule

// File: rtl/multi_button_detect.sv
// N-channel push-button conditioner: one shared sample-tick generator feeding
// N independent button channels.
module multi_button_detect
   import btn_pkg::*;
#(
   parameter int N_BTN        = 5,
   parameter int TICK_DIV     = 250_000,
   parameter int SYNC_STAGES  = 2,
   parameter int DB_SAMPLES   = 3,
   parameter int HOLD_TICKS   = 200,
   parameter int REPEAT_TICKS = 50
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_BTN-1:0]   btn_in,
   input  logic [N_BTN-1:0]   repeat_en,
   output logic [N_BTN-1:0]   btn_level,
   output logic [N_BTN-1:0]   press,
   output logic [N_BTN-1:0]   btn_release,
   output logic [N_BTN-1:0]   long_press,
   output logic [N_BTN-1:0]   repeat_pulse,
   output state_t [N_BTN-1:0] dbg_state
);

   localparam int TICK_W = $clog2(TICK_DIV);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

   logic [TICK_W-1:0] r_tick_cnt;
   logic              w_tick;

   assign w_tick = (r_tick_cnt == TICK_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tick_cnt <= '0;
      end else if (w_tick) begin
         r_tick_cnt <= '0;
      end else begin
         r_tick_cnt <= r_tick_cnt + TICK_W'(1);
      end
   end

   for (genvar g = 0; g < N_BTN; g++) begin : g_ch
      btn_channel #(
         .SYNC_STAGES  (SYNC_STAGES),
         .DB_SAMPLES   (DB_SAMPLES),
         .HOLD_TICKS   (HOLD_TICKS),
         .REPEAT_TICKS (REPEAT_TICKS)
      ) u_ch (
         .i_clk          (clk),
         .i_rst          (rst),
         .i_tick         (w_tick),
         .i_btn          (btn_in[g]),
         .i_repeat_en    (repeat_en[g]),
         .o_level        (btn_level[g]),
         .o_press        (press[g]),
         .o_release      (btn_release[g]),
         .o_long_press   (long_press[g]),
         .o_repeat_pulse (repeat_pulse[g]),
         .o_state        (dbg_state[g])
      );
   end

endmodule

// File: tb/tb_multi_button_detect.sv
// Randomised bench for multi_button_detect: an event-level reference model
// fills an expected-pulse queue; a negedge monitor pops and compares.
module tb_multi_button_detect;
   import btn_pkg::*;

   localparam int N  = 2;
   localparam int TD = 4;
   localparam int SS = 2;
   localparam int DB = 3;
   localparam int HT = 5;
   localparam int RT = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   btn_in;
   logic [N-1:0]   repeat_en;
   logic [N-1:0]   btn_level;
   logic [N-1:0]   press;
   logic [N-1:0]   btn_release;
   logic [N-1:0]   long_press;
   logic [N-1:0]   repeat_pulse;
   state_t [N-1:0] dbg_state;

   always #5 clk = ~clk;

   multi_button_detect #(
      .N_BTN        (N),
      .TICK_DIV     (TD),
      .SYNC_STAGES  (SS),
      .DB_SAMPLES   (DB),
      .HOLD_TICKS   (HT),
      .REPEAT_TICKS (RT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .btn_in       (btn_in),
      .repeat_en    (repeat_en),
      .btn_level    (btn_level),
      .press        (press),
      .btn_release  (btn_release),
      .long_press   (long_press),
      .repeat_pulse (repeat_pulse),
      .dbg_state    (dbg_state)
   );

   int total = 0;
   int bad   = 0;

   // Event entry: {channel, cycle stamp, kind}; kind 0=press 1=release 2=long 3=repeat.
   logic [34:0]  exp_q[$];
   logic [31:0]  cyc_abs = 0;
   int           ncyc;
   logic [N-1:0] hist[$];
   logic [N-1:0] m_lvl;
   int           m_run[N];
   int           m_phase[N];
   int           m_since[N];
   int           m_en_run[N];

   task automatic push_ev(input int ch, input int kind);
      logic [34:0] e;
      e = {ch[0], cyc_abs, kind[1:0]};
      exp_q.push_back(e);
   endtask

   // Reference: level follows DB consecutive disagreeing tick samples of the
   // input delayed by SS cycles; long press after HT further ticks; repeats
   // after every RT consecutive enabled ticks.
   task automatic model_step();
      logic tick;
      logic s;
      logic changed;
      cyc_abs = cyc_abs + 1;
      if (rst) begin
         hist.delete();
         ncyc  = 0;
         m_lvl = '0;
         for (int c = 0; c < N; c++) begin
            m_run[c] = 0; m_phase[c] = 0; m_since[c] = 0; m_en_run[c] = 0;
         end
         return;
      end
      hist.push_back(btn_in);
      tick = ((ncyc % TD) == TD - 1);
      for (int c = 0; c < N; c++) begin
         s       = (ncyc >= SS) ? hist[ncyc-SS][c] : 1'b0;
         changed = 1'b0;
         if (tick) begin
            if (s != m_lvl[c]) begin
               m_run[c]++;
               if (m_run[c] == DB) begin
                  m_run[c] = 0;
                  m_lvl[c] = s;
                  changed  = 1'b1;
                  push_ev(c, s ? 0 : 1);
                  m_phase[c]  = s ? 1 : 0;
                  m_since[c]  = 0;
                  m_en_run[c] = 0;
               end
            end else begin
               m_run[c] = 0;
            end
         end
         if (!changed) begin
            if (m_phase[c] == 1) begin
               if (tick) begin
                  m_since[c]++;
                  if (m_since[c] == HT) begin
                     push_ev(c, 2);
                     m_phase[c]  = 2;
                     m_en_run[c] = 0;
                  end
               end
            end else if (m_phase[c] == 2) begin
               if (!repeat_en[c]) begin
                  m_en_run[c] = 0;
               end else if (tick) begin
                  m_en_run[c]++;
                  if (m_en_run[c] == RT) begin
                     push_ev(c, 3);
                     m_en_run[c] = 0;
                  end
               end
            end
         end
      end
      ncyc++;
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   task automatic check_cycle();
      logic [34:0] e;
      logic [34:0] want;
      logic [31:0] ec;
      logic        pulse;
      logic [1:0]  st;
      while (exp_q.size() > 0) begin
         e  = exp_q[0];
         ec = e[33:2];
         if (ec >= cyc_abs) break;
         total++; bad++;
         $display("FAIL missed_event ch%0d kind=%0d due_cyc=%0d got=none at cyc=%0d",
                  e[34], e[1:0], ec, cyc_abs);
         void'(exp_q.pop_front());
      end
      for (int c = 0; c < N; c++) begin
         for (int k = 0; k < 4; k++) begin
            case (k)
               0:       pulse = press[c];
               1:       pulse = btn_release[c];
               2:       pulse = long_press[c];
               default: pulse = repeat_pulse[c];
            endcase
            if (pulse === 1'b1) begin
               total++;
               want = {c[0], cyc_abs, k[1:0]};
               if (exp_q.size() == 0) begin
                  bad++;
                  $display("FAIL unexpected_pulse ch%0d kind=%0d cyc=%0d required=none", c, k, cyc_abs);
               end else begin
                  e = exp_q.pop_front();
                  if (e !== want) begin
                     bad++;
                     $display("FAIL pulse ch%0d got kind=%0d cyc=%0d required ch%0d kind=%0d cyc=%0d",
                              c, k, cyc_abs, e[34], e[1:0], e[33:2]);
                  end
               end
            end
         end
         total++;
         if (btn_level[c] !== m_lvl[c]) begin
            bad++;
            $display("FAIL btn_level ch%0d cyc=%0d got=%b required=%b", c, cyc_abs, btn_level[c], m_lvl[c]);
         end
         st = dbg_state[c];
         total++;
         if (st !== 2'(m_phase[c])) begin
            bad++;
            $display("FAIL fsm_state ch%0d cyc=%0d got=%0d required=%0d", c, cyc_abs, st, m_phase[c]);
         end
      end
   endtask

   initial forever begin
      @(negedge clk);
      check_cycle();
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   initial begin
      int n;
      rst = 1'b1; btn_in = 2'b11; repeat_en = 2'b00;
      step(3);
      rst = 1'b0;
      step(30);
      btn_in = 2'b00;
      step(25);
      // Clean short press on channel 0.
      btn_in = 2'b01;
      step(30);
      btn_in = 2'b00;
      step(25);
      // Bouncing channel 1, then a one-tick glitch.
      for (int k = 0; k < 14; k++) begin
         btn_in[1] = ~btn_in[1];
         step(3);
      end
      btn_in = 2'b00;
      step(20);
      btn_in[1] = 1'b1;
      step(TD);
      btn_in[1] = 1'b0;
      step(20);
      // Long hold with and without auto-repeat, then repeat enabled mid-hold.
      repeat_en = 2'b01; btn_in = 2'b01;
      step(120);
      btn_in = 2'b00;
      step(30);
      repeat_en = 2'b00; btn_in = 2'b01;
      step(120);
      btn_in = 2'b00;
      step(30);
      btn_in = 2'b01;
      step(50);
      repeat_en = 2'b01;
      step(70);
      btn_in = 2'b00;
      step(30);
      repeat_en = 2'b00;
      // Reset while channel 0 is held and channel 1 is pressed.
      btn_in = 2'b01;
      step(30);
      btn_in = 2'b11;
      step(20);
      rst = 1'b1;
      step(2);
      rst = 1'b0; btn_in = 2'b00;
      step(30);
      // Random segments with occasional resets.
      for (int seg = 0; seg < 250; seg++) begin
         btn_in    = 2'($urandom_range(0, 3));
         repeat_en = 2'($urandom_range(0, 3));
         n = ($urandom_range(0, 3) == 0) ? $urandom_range(40, 120) : $urandom_range(1, 20);
         if ($urandom_range(0, 39) == 0) begin
            rst = 1'b1;
            step($urandom_range(1, 3));
            rst = 1'b0;
         end
         step(n);
      end
      btn_in = 2'b00; repeat_en = 2'b00;
      step(40);
      while (exp_q.size() > 0) begin
         logic [34:0] e;
         e = exp_q.pop_front();
         total++; bad++;
         $display("FAIL missed_event_at_end ch%0d kind=%0d due_cyc=%0d got=none", e[34], e[1:0], e[33:2]);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
